// File: rtl/main_control_fsm.sv
// Multicycle processor main control FSM: sequences fetch/decode/execute,
// waits on the memory handshake with a timeout, and latches a sticky fault.
module main_control_fsm #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] Opcode,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       PCSource,
  output logic       Fault,
  output logic [1:0] FaultCause,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ERROR    = 4'd9
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [7:0] TMO      = 8'(TIMEOUT);

  localparam logic [1:0] C_ILLEGAL = 2'b01;
  localparam logic [1:0] C_TIMEOUT = 2'b10;

  state_t     state, state_n;
  logic [7:0] wcnt, wcnt_n;
  logic [1:0] cause, cause_n;
  logic       mem_st, tmo;

  assign mem_st     = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
  assign tmo        = (wcnt == TMO);
  assign State      = state;
  assign FaultCause = cause;

  always_comb begin
    state_n     = state;
    cause_n     = cause;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 1'b0;
    Fault       = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // A completing access beats a timeout in the same cycle.
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_n = DECODE;
        end else if (tmo) begin
          state_n = ERROR;
          cause_n = C_TIMEOUT;
        end
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LOAD, OP_STORE: state_n = MEMADR;
          OP_RTYPE:          state_n = EXECUTE;
          OP_BR:             state_n = BRANCH;
          default: begin
            state_n = ERROR;
            cause_n = C_ILLEGAL;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_n = (Opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) state_n = MEMWB;
        else if (tmo) begin
          state_n = ERROR;
          cause_n = C_TIMEOUT;
        end
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_n  = FETCH;
      end
      MEMWRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) state_n = FETCH;
        else if (tmo) begin
          state_n = ERROR;
          cause_n = C_TIMEOUT;
        end
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_n = ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        state_n  = FETCH;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        state_n     = FETCH;
      end
      ERROR: Fault = 1'b1;
      default: begin
        state_n = ERROR;
        cause_n = C_ILLEGAL;
      end
    endcase
  end

  // Any state change clears the counter, so entry to a memory state starts at 0.
  always_comb begin
    wcnt_n = wcnt;
    if (state_n != state)                         wcnt_n = 8'd0;
    else if (mem_st && !MemReady && wcnt != 8'hFF) wcnt_n = wcnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      wcnt  <= 8'd0;
      cause <= 2'b00;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      cause <= cause_n;
    end
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: state sequences, output decode,
// illegal opcode, memory timeout and reset override.
module tb_main_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] Opcode = 7'b0110011;
  logic       MemReady = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, ALUSrcA, PCSource, Fault;
  logic [1:0] ALUSrcB, ALUOp, FaultCause;
  logic [3:0] State;
  logic [16:0] outs;

  int cmp = 0;
  int err = 0;

  main_control_fsm #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .Fault(Fault), .FaultCause(FaultCause), .State(State)
  );

  always #5 clk = ~clk;

  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,ALUSrcA,
  //  ALUSrcB,ALUOp,PCSource,Fault,FaultCause}
  assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Fault, FaultCause};

  localparam logic [16:0] O_F1  = 17'b100101000_01_00_0_0_00;
  localparam logic [16:0] O_F0  = 17'b000100000_01_00_0_0_00;
  localparam logic [16:0] O_DEC = 17'b000000000_11_00_0_0_00;
  localparam logic [16:0] O_MA  = 17'b000000001_10_00_0_0_00;
  localparam logic [16:0] O_MR  = 17'b001100000_00_00_0_0_00;
  localparam logic [16:0] O_MWB = 17'b000000110_00_00_0_0_00;
  localparam logic [16:0] O_MW  = 17'b001010000_00_00_0_0_00;
  localparam logic [16:0] O_EX  = 17'b000000001_00_10_0_0_00;
  localparam logic [16:0] O_AWB = 17'b000000010_00_00_0_0_00;
  localparam logic [16:0] O_BR  = 17'b010000001_00_01_1_0_00;
  localparam logic [16:0] O_E01 = 17'b000000000_00_00_0_1_01;
  localparam logic [16:0] O_E10 = 17'b000000000_00_00_0_1_10;

  task automatic do_reset();
    reset = 1'b1;
    MemReady = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    cmp++; if (State !== 4'd0) begin $display("FAIL reset_state got %0d want 0", State); err++; end
    cmp++; if (outs !== O_F0) begin $display("FAIL reset_outs got %b want %b", outs, O_F0); err++; end
    MemReady = 1'b1; #1;
    cmp++; if (outs !== O_F1) begin $display("FAIL reset_outs_ready got %b want %b", outs, O_F1); err++; end
  endtask

  task automatic test_rtype();
    logic [3:0]  st[5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic [16:0] eo[5] = '{O_F1, O_DEC, O_EX, O_AWB, O_F1};
    Opcode = 7'b0110011;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      MemReady = 1'b1; #1;
      cmp++; if (State !== st[i]) begin $display("FAIL rtype_state[%0d] got %0d want %0d", i, State, st[i]); err++; end
      cmp++; if (outs !== eo[i]) begin $display("FAIL rtype_outs[%0d] got %b want %b", i, outs, eo[i]); err++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    logic        mr[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0]  st[9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic [16:0] eo[9] = '{O_F1, O_DEC, O_MA, O_MR, O_MR, O_MR, O_MR, O_MWB, O_F0};
    Opcode = 7'b0000011;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      MemReady = mr[i]; #1;
      cmp++; if (State !== st[i]) begin $display("FAIL load_state[%0d] got %0d want %0d", i, State, st[i]); err++; end
      cmp++; if (outs !== eo[i]) begin $display("FAIL load_outs[%0d] got %b want %b", i, outs, eo[i]); err++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store();
    logic [3:0]  st[5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    logic [16:0] eo[5] = '{O_F1, O_DEC, O_MA, O_MW, O_F1};
    Opcode = 7'b0100011;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      MemReady = 1'b1; #1;
      cmp++; if (State !== st[i]) begin $display("FAIL store_state[%0d] got %0d want %0d", i, State, st[i]); err++; end
      cmp++; if (outs !== eo[i]) begin $display("FAIL store_outs[%0d] got %b want %b", i, outs, eo[i]); err++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_reset();
    Opcode = 7'b0100011;
    do_reset();
    MemReady = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    MemReady = 1'b0;
    @(posedge clk); #1;
    cmp++; if (State !== 4'd5) begin $display("FAIL stres_wait got %0d want 5", State); err++; end
    cmp++; if (outs !== O_MW) begin $display("FAIL stres_wait_outs got %b want %b", outs, O_MW); err++; end
    do_reset();
    #1;
    cmp++; if (State !== 4'd0) begin $display("FAIL stres_state got %0d want 0", State); err++; end
    cmp++; if (MemWrite !== 1'b0) begin $display("FAIL stres_memwrite got %b want 0", MemWrite); err++; end
    cmp++; if (outs !== O_F0) begin $display("FAIL stres_outs got %b want %b", outs, O_F0); err++; end
  endtask

  task automatic test_branch();
    logic [3:0]  st[4] = '{4'd0, 4'd1, 4'd8, 4'd0};
    logic [16:0] eo[4] = '{O_F1, O_DEC, O_BR, O_F1};
    Opcode = 7'b1100011;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      MemReady = 1'b1; #1;
      cmp++; if (State !== st[i]) begin $display("FAIL branch_state[%0d] got %0d want %0d", i, State, st[i]); err++; end
      cmp++; if (outs !== eo[i]) begin $display("FAIL branch_outs[%0d] got %b want %b", i, outs, eo[i]); err++; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    Opcode = 7'b1111111;
    do_reset();
    MemReady = 1'b1;
    @(posedge clk); #1;
    cmp++; if (State !== 4'd1) begin $display("FAIL illegal_decode got %0d want 1", State); err++; end
    @(posedge clk); #1;
    MemReady = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      cmp++; if (State !== 4'd9) begin $display("FAIL illegal_state[%0d] got %0d want 9", i, State); err++; end
      cmp++; if (outs !== O_E01) begin $display("FAIL illegal_outs[%0d] got %b want %b", i, outs, O_E01); err++; end
      MemReady = ~MemReady;
      @(posedge clk); #1;
    end
    do_reset();
    #1;
    cmp++; if (State !== 4'd0) begin $display("FAIL illegal_rst_state got %0d want 0", State); err++; end
    cmp++; if ({Fault, FaultCause} !== 3'b000) begin $display("FAIL illegal_rst_fault got %b want 000", {Fault, FaultCause}); err++; end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      #1;
      cmp++; if (State !== 4'd0) begin $display("FAIL tmo_fetch[%0d] got %0d want 0", i, State); err++; end
      @(posedge clk); #1;
    end
    #1;
    cmp++; if (State !== 4'd9) begin $display("FAIL tmo_state got %0d want 9", State); err++; end
    cmp++; if (outs !== O_E10) begin $display("FAIL tmo_outs got %b want %b", outs, O_E10); err++; end
    // Ready on the 16th cycle completes instead of faulting.
    do_reset();
    repeat (15) begin @(posedge clk); #1; end
    MemReady = 1'b1; #1;
    cmp++; if (outs !== O_F1) begin $display("FAIL tmo_race_outs got %b want %b", outs, O_F1); err++; end
    @(posedge clk); #1;
    cmp++; if (State !== 4'd1) begin $display("FAIL tmo_race_state got %0d want 1", State); err++; end
    cmp++; if ({Fault, FaultCause} !== 3'b000) begin $display("FAIL tmo_race_fault got %b want 000", {Fault, FaultCause}); err++; end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_store();
    test_store_reset();
    test_branch();
    test_illegal();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 15: maximum wait-counter value in a memory state before a bus fault; legal range 0..255.
REQ-002 SHALL provide clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL provide reset, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL provide Opcode, input, 7: instruction bits [6:0] from the instruction register, held stable outside FETCH.
REQ-005 SHALL provide MemReady, input, 1: memory handshake; high means the current access completes this cycle.
REQ-006 SHALL provide PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite and ALUSrcA as 1-bit outputs: datapath enables and selects.
REQ-007 SHALL provide ALUSrcB, output, 2: ALU B select; 00 = reg, 01 = constant 4, 10 = imm, 11 = branch offset.
REQ-008 SHALL provide ALUOp, output, 2: ALU operation class for the downstream ALU control; 00 = add, 01 = subtract/compare, 10 = use funct.
REQ-009 SHALL provide PCSource, output, 1: PC select; 0 = ALU result, 1 = branch target.
REQ-010 SHALL provide Fault, output, 1: sticky error flag.
REQ-011 SHALL provide FaultCause, output, 2: 00 = none, 01 = illegal opcode, 10 = memory timeout.
REQ-012 SHALL provide State, output, 4: current state encoding, for debug.

Function
REQ-013 SHALL implement the following state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ERROR=9; codes 10..15 SHALL go to ERROR with cause 01 on the next edge.
REQ-014 SHALL drive all outputs to 0 in every state except where listed below, and SHALL never drive an output to X.
REQ-015 FETCH: SHALL drive MemRead=1, ALUSrcB=01 and ALUOp=00; IRWrite=1 and PCWrite=1 only in the same cycle as MemReady=1, and the next state is DECODE; otherwise SHALL remain in FETCH.
REQ-016 DECODE: SHALL drive ALUSrcB=11 and ALUOp=00, then branch on Opcode: 0000011 (load) or 0100011 (store) to MEMADR, 0110011 (R-type) to EXECUTE, 1100011 (branch) to BRANCH, any other value to ERROR with cause 01.
REQ-017 MEMADR: SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUOp=00; next state is MEMREAD if Opcode is load, else MEMWRITE.
REQ-018 MEMREAD: SHALL drive MemRead=1 and IorD=1; MemReady=1 moves to MEMWB, otherwise SHALL wait.
REQ-019 MEMWB: SHALL drive RegWrite=1 and MemtoReg=1; next state is FETCH.
REQ-020 MEMWRITE: SHALL drive MemWrite=1 and IorD=1; MemReady=1 moves to FETCH, otherwise SHALL wait.
REQ-021 EXECUTE: SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUOp=10; next state is ALUWB.
REQ-022 ALUWB: SHALL drive RegWrite=1 and MemtoReg=0; next state is FETCH.
REQ-023 BRANCH: SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1 and PCSource=1; next state is FETCH.
REQ-024 ERROR: SHALL drive all datapath outputs to 0 and Fault=1, and SHALL stay in ERROR until reset.
REQ-025 Wait counter: SHALL be an 8-bit counter, cleared on entry to FETCH, MEMREAD or MEMWRITE, incremented each cycle those states wait with MemReady=0, and saturating (never wrapping).
REQ-026 Timeout: in a memory state with MemReady=0 and counter==TIMEOUT, the next state SHALL be ERROR with cause 10; MemReady=1 in that same cycle SHALL win and complete normally.
REQ-027 Instruction latency: R-type SHALL take 4 cycles, load 5, store 4 and branch 3, each with zero wait states.
REQ-028 FaultCause SHALL be latched on entry to ERROR and held until reset.

Reset
REQ-029 reset=1 at a rising edge SHALL force State=FETCH, clear the wait counter, Fault=0 and FaultCause=00, overriding any state, including ERROR and mid-wait.
REQ-030 In the cycle after reset the outputs SHALL be the FETCH values: MemRead=1, ALUSrcB=01, all others 0, with IRWrite and PCWrite gated by MemReady.

Verification
REQ-031 Reset, then MemReady=1 held and Opcode=0110011 -> State sequence 0,1,6,7,0; RegWrite=1 only in state 7; ALUOp=10 only in state 6.
REQ-032 Opcode=0000011 with MemReady low for 3 cycles in MEMREAD -> State sequence 0,1,2,3,3,3,3,4,0; MemtoReg=1 in state 4.
REQ-033 Opcode=1100011 -> State sequence 0,1,8,0; PCWriteCond=1, PCSource=1 and ALUOp=01 in state 8.
REQ-034 Opcode=1111111 in DECODE -> State=9, Fault=1, FaultCause=01 held for 20 cycles; reset -> State=0, Fault=0.
REQ-035 TIMEOUT=15 with MemReady=0 in FETCH -> ERROR entered after exactly 16 FETCH cycles with FaultCause=10; a repeat run with MemReady=1 on the 16th cycle -> DECODE and no fault.
REQ-036 Opcode=0100011, reset asserted mid-MEMWRITE -> next State=0 and MemWrite=0 with no write completed.
